// File: rtl/full_stage_mac_if.sv
// Stream bundle for full_stage_mac: tap load, input vector elements, result drain.
// Latency: n/a (wires only).
// Backpressure: each stream uses a valid/ready pair; the slave side is the MAC stage.
interface full_stage_mac_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
);
   logic [DATA_W-1:0] tap_in;
   logic              tap_in_vld;
   logic              tap_in_fst;
   logic              tap_in_rdy;
   logic [DATA_W-1:0] stage_data;
   logic              stage_data_vld;
   logic              stage_data_fst;
   logic              stage_data_rdy;
   logic [ACC_W-1:0]  stage_data_out;
   logic              stage_data_out_vld;
   logic              stage_data_out_fst;
   logic              stage_data_out_rdy;
   logic              load_finish;

   modport master (
      output tap_in, tap_in_vld, tap_in_fst,
      input  tap_in_rdy,
      output stage_data, stage_data_vld, stage_data_fst,
      input  stage_data_rdy,
      input  stage_data_out, stage_data_out_vld, stage_data_out_fst,
      output stage_data_out_rdy,
      input  load_finish
   );

   modport slave (
      input  tap_in, tap_in_vld, tap_in_fst,
      output tap_in_rdy,
      input  stage_data, stage_data_vld, stage_data_fst,
      output stage_data_rdy,
      output stage_data_out, stage_data_out_vld, stage_data_out_fst,
      input  stage_data_out_rdy,
      output load_finish
   );
endinterface

// File: rtl/full_stage_mac.sv
// Multi-lane fixed-point fully-connected stage: LANES dot products of DEPTH elements plus bias.
// Latency: lane 0 result valid the cycle after the last element; one lane per cycle after that.
// Backpressure: results held until accepted; no input accepted while draining or loading taps.
module full_stage_mac #(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 40,
   parameter int DEPTH   = 8,
   parameter int LANES   = 4,
   parameter int BIAS_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   full_stage_mac_if.slave bus
);
   localparam int WPL = DEPTH + BIAS_EN;                  // load words per lane
   localparam int IW  = $clog2(DEPTH);
   localparam int PW  = $clog2(WPL);
   localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PRW = 2 * DATA_W;

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

   state_t                    state_q, state_d;
   logic signed [DATA_W-1:0]  tap_q  [LANES][DEPTH];
   logic signed [DATA_W-1:0]  tap_d  [LANES][DEPTH];
   logic signed [DATA_W-1:0]  bias_q [LANES];
   logic signed [DATA_W-1:0]  bias_d [LANES];
   logic signed [ACC_W-1:0]   acc_q  [LANES];
   logic signed [ACC_W-1:0]   acc_d  [LANES];
   logic signed [ACC_W-1:0]   out_q  [LANES];
   logic signed [ACC_W-1:0]   out_d  [LANES];
   logic [IW-1:0]             idx_q, idx_d;
   logic [LW-1:0]             ld_lane_q, ld_lane_d;
   logic [PW-1:0]             ld_pos_q, ld_pos_d;
   logic [LW-1:0]             lane_q, lane_d;
   logic                      load_finish_q, load_finish_d;

   logic                      reload, tap_rdy, dat_rdy, tap_acc, dat_acc;
   logic                      first_elem;
   logic [IW-1:0]             eff_idx;
   logic [LW-1:0]             eff_lane;
   logic [PW-1:0]             eff_pos;
   logic signed [PRW-1:0]     prod    [LANES];
   logic signed [ACC_W-1:0]   acc_sum [LANES];
   logic signed [ACC_W-1:0]   result  [LANES];

   // A reload is only taken between vectors, and steals the cycle from the data stream.
   assign reload  = (state_q == S_RUN) && (idx_q == '0) && bus.tap_in_vld && bus.tap_in_fst;
   assign tap_rdy = !reset && ((state_q == S_LOAD) || reload);
   assign dat_rdy = !reset && (state_q == S_RUN) && !reload;
   assign tap_acc = tap_rdy && bus.tap_in_vld;
   assign dat_acc = dat_rdy && bus.stage_data_vld;

   // fst forces the vector to restart; index 0 always starts from a clean accumulator.
   assign first_elem = bus.stage_data_fst || (idx_q == '0);
   assign eff_idx    = bus.stage_data_fst ? '0 : idx_q;
   assign eff_lane   = bus.tap_in_fst ? '0 : ld_lane_q;
   assign eff_pos    = bus.tap_in_fst ? '0 : ld_pos_q;

   assign bus.tap_in_rdy         = tap_rdy;
   assign bus.stage_data_rdy     = dat_rdy;
   assign bus.stage_data_out_vld = (state_q == S_DRAIN);
   assign bus.stage_data_out_fst = (state_q == S_DRAIN) && (lane_q == '0);
   assign bus.stage_data_out     = (state_q == S_DRAIN) ? out_q[lane_q] : '0;
   assign bus.load_finish        = load_finish_q;

   // Per-lane full-width product, running sum and biased result for the current element.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         prod[l]    = PRW'($signed(bus.stage_data)) * PRW'(tap_q[l][eff_idx]);
         acc_sum[l] = (first_elem ? '0 : acc_q[l])
                      + {{(ACC_W-PRW){prod[l][PRW-1]}}, prod[l]};
         result[l]  = acc_sum[l] + {{(ACC_W-DATA_W){bias_q[l][DATA_W-1]}}, bias_q[l]};
      end
   end

   // Next-state for the LOAD / RUN / DRAIN sequencer and its storage.
   always_comb begin
      state_d       = state_q;
      tap_d         = tap_q;
      bias_d        = bias_q;
      acc_d         = acc_q;
      out_d         = out_q;
      idx_d         = idx_q;
      ld_lane_d     = ld_lane_q;
      ld_pos_d      = ld_pos_q;
      lane_d        = lane_q;
      load_finish_d = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (tap_acc) begin
               if (int'(eff_pos) < DEPTH) tap_d[eff_lane][eff_pos[IW-1:0]] = bus.tap_in;
               else                       bias_d[eff_lane] = bus.tap_in;
               if (eff_pos == PW'(WPL - 1)) begin
                  ld_pos_d = '0;
                  if (eff_lane == LW'(LANES - 1)) begin
                     ld_lane_d     = '0;
                     load_finish_d = 1'b1;
                     state_d       = S_RUN;
                  end else begin
                     ld_lane_d = eff_lane + LW'(1);
                  end
               end else begin
                  ld_lane_d = eff_lane;
                  ld_pos_d  = eff_pos + PW'(1);
               end
            end
         end
         S_RUN: begin
            if (reload) begin
               tap_d[0][0] = bus.tap_in;
               ld_lane_d   = '0;
               ld_pos_d    = PW'(1);
               state_d     = S_LOAD;
            end else if (dat_acc) begin
               if (eff_idx == IW'(DEPTH - 1)) begin
                  for (int l = 0; l < LANES; l++) begin
                     out_d[l] = result[l];
                     acc_d[l] = '0;
                  end
                  idx_d   = '0;
                  lane_d  = '0;
                  state_d = S_DRAIN;
               end else begin
                  acc_d = acc_sum;
                  idx_d = eff_idx + IW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (bus.stage_data_out_rdy) begin
               if (lane_q == LW'(LANES - 1)) begin
                  lane_d  = '0;
                  state_d = S_RUN;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // All state registers; reset wipes taps so a full reload is needed afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_LOAD;
         idx_q         <= '0;
         ld_lane_q     <= '0;
         ld_pos_q      <= '0;
         lane_q        <= '0;
         load_finish_q <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            bias_q[l] <= '0;
            acc_q[l]  <= '0;
            out_q[l]  <= '0;
            for (int d = 0; d < DEPTH; d++) tap_q[l][d] <= '0;
         end
      end else begin
         state_q       <= state_d;
         tap_q         <= tap_d;
         bias_q        <= bias_d;
         acc_q         <= acc_d;
         out_q         <= out_d;
         idx_q         <= idx_d;
         ld_lane_q     <= ld_lane_d;
         ld_pos_q      <= ld_pos_d;
         lane_q        <= lane_d;
         load_finish_q <= load_finish_d;
      end
   end
endmodule

// File: tb/tb_full_stage_mac.sv
// Bench for full_stage_mac: directed scenarios plus randomized vectors against a dot-product model.
// Latency: checks result timing relative to the last accepted element.
// Backpressure: exercises held results under stalled and random downstream ready.
module tb_full_stage_mac;
   localparam int DATA_W  = 16;
   localparam int ACC_W   = 40;
   localparam int DEPTH   = 4;
   localparam int LANES   = 2;
   localparam int BIAS_EN = 1;
   localparam int WPL     = DEPTH + BIAS_EN;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   full_stage_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bif ();

   full_stage_mac #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .LANES(LANES), .BIAS_EN(BIAS_EN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int checks   = 0;
   int failures = 0;

   // Reference state: loaded coefficients, elements of the vector in progress, expected results.
   longint m_tap  [LANES][DEPTH];
   longint m_bias [LANES];
   longint mq [$];
   longint exp_out [LANES];

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic longint wrap(input longint v);
      longint m;
      m = v & ((longint'(1) << ACC_W) - 1);
      if (m >= (longint'(1) << (ACC_W - 1))) m = m - (longint'(1) << ACC_W);
      return m;
   endfunction

   function automatic longint rnd16();
      logic signed [15:0] r;
      case ($urandom_range(0, 5))
         0:       r = 16'sh7fff;
         1:       r = 16'sh8000;
         default: r = 16'($urandom);
      endcase
      return longint'(r);
   endfunction

   function automatic longint out_val();
      logic signed [ACC_W-1:0] v;
      v = bif.stage_data_out;
      return longint'(v);
   endfunction

   // Dot product of the completed vector with each lane's taps, plus bias, wrapped to ACC_W.
   task automatic model_complete();
      for (int l = 0; l < LANES; l++) begin
         longint s;
         s = (BIAS_EN != 0) ? m_bias[l] : 0;
         for (int i = 0; i < DEPTH; i++) s = s + mq[i] * m_tap[l][i];
         exp_out[l] = wrap(s);
      end
      mq.delete();
   endtask

   // Starts and ends at a negedge; expects the word to be taken on the next edge.
   task automatic send_tap(input longint w, input bit f);
      int n;
      n = 0;
      bif.tap_in = 16'(w); bif.tap_in_vld = 1'b1; bif.tap_in_fst = f;
      #1;
      while (bif.tap_in_rdy !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      chk("tap_wait", n, 0);
      @(posedge clk);
      @(negedge clk);
      bif.tap_in_vld = 1'b0; bif.tap_in_fst = 1'b0;
   endtask

   task automatic feed(input longint d, input bit f);
      int n;
      n = 0;
      bif.stage_data = 16'(d); bif.stage_data_vld = 1'b1; bif.stage_data_fst = f;
      #1;
      while (bif.stage_data_rdy !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      chk("data_no_bubble", n, 0);
      @(posedge clk);
      if (f) mq.delete();
      mq.push_back(d);
      if (mq.size() == DEPTH) model_complete();
      @(negedge clk);
      bif.stage_data_vld = 1'b0; bif.stage_data_fst = 1'b0;
   endtask

   // Sends the whole m_tap/m_bias image lane-major; word 0 may already have gone out.
   task automatic load_taps(input bit skip_first);
      for (int w = 0; w < LANES * WPL; w++) begin
         int l, p;
         l = w / WPL; p = w % WPL;
         if (!(skip_first && w == 0))
            send_tap((p < DEPTH) ? m_tap[l][p] : m_bias[l], w == 0);
         if (w == LANES * WPL - 1) begin
            chk("load_finish", bif.load_finish, 1);
            chk("rdy_after_load", bif.stage_data_rdy, 1);
            @(negedge clk);
            chk("load_finish_pulse", bif.load_finish, 0);
         end else if (!(skip_first && w == 0)) begin
            chk("load_finish_early", bif.load_finish, 0);
         end
      end
   endtask

   // mode 0: ready held high; mode 1: five stalled cycles first; mode 2: random ready.
   task automatic drain(input int mode);
      int stall, total;
      stall = 0; total = 0;
      for (int k = 0; k < LANES; k++) begin
         bit taken;
         int n;
         taken = 1'b0; n = 0;
         while (!taken && n < 50) begin
            chk("out_vld", bif.stage_data_out_vld, 1);
            chk("out_dat", out_val(), exp_out[k]);
            chk("out_fst", bif.stage_data_out_fst, (k == 0) ? 1 : 0);
            chk("in_blocked", bif.stage_data_rdy, 0);
            if (mode == 0) bif.stage_data_out_rdy = 1'b1;
            else if (mode == 1) begin bif.stage_data_out_rdy = (stall >= 5); stall++; end
            else bif.stage_data_out_rdy = ($urandom_range(0, 2) != 0);
            taken = bif.stage_data_out_rdy;
            @(negedge clk);
            n++; total++;
         end
         chk("drain_timeout", (n >= 50) ? 1 : 0, 0);
      end
      if (mode == 0) chk("drain_cycles", total, LANES);
      if (mode == 1) chk("drain_stall_cycles", total, LANES + 5);
      chk("drain_done_vld", bif.stage_data_out_vld, 0);
      chk("rdy_after_drain", bif.stage_data_rdy, 1);
      bif.stage_data_out_rdy = 1'b1;
   endtask

   task automatic set_basic_taps();
      for (int i = 0; i < DEPTH; i++) begin
         m_tap[0][i] = i + 1;
         m_tap[1][i] = -1;
      end
      m_bias[0] = 10; m_bias[1] = 0;
   endtask

   task automatic feed_ones();
      for (int e = 0; e < DEPTH; e++) feed(1, e == 0);
   endtask

   initial begin
      reset = 1'b1;
      bif.tap_in = '0; bif.tap_in_vld = 1'b0; bif.tap_in_fst = 1'b0;
      bif.stage_data = '0; bif.stage_data_vld = 1'b0; bif.stage_data_fst = 1'b0;
      bif.stage_data_out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tap_rdy", bif.tap_in_rdy, 0);
      chk("rst_data_rdy", bif.stage_data_rdy, 0);
      chk("rst_out_vld", bif.stage_data_out_vld, 0);
      chk("rst_out_fst", bif.stage_data_out_fst, 0);
      chk("rst_out", out_val(), 0);
      chk("rst_load_finish", bif.load_finish, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_tap_rdy", bif.tap_in_rdy, 1);
      chk("load_data_rdy", bif.stage_data_rdy, 0);

      // Basic load and compute
      set_basic_taps();
      load_taps(1'b0);
      feed_ones();
      chk("exp_basic_l0", exp_out[0], 20);
      chk("exp_basic_l1", exp_out[1], -4);
      drain(0);

      // Backpressure on lane 0
      feed_ones();
      drain(1);

      // fst restart, with a tap-fst attempt mid-vector that must be ignored
      feed(5, 1'b1);
      feed(5, 1'b0);
      bif.tap_in = 16'd99; bif.tap_in_vld = 1'b1; bif.tap_in_fst = 1'b1;
      #1;
      chk("midvec_tap_rdy", bif.tap_in_rdy, 0);
      chk("midvec_data_rdy", bif.stage_data_rdy, 1);
      @(negedge clk);
      bif.tap_in_vld = 1'b0; bif.tap_in_fst = 1'b0;
      feed_ones();
      drain(0);

      // Non-first tap word in RUN is not accepted
      bif.tap_in = 16'd7; bif.tap_in_vld = 1'b1; bif.tap_in_fst = 1'b0;
      #1;
      chk("run_tap_nofst_rdy", bif.tap_in_rdy, 0);
      @(negedge clk);
      bif.tap_in_vld = 1'b0;

      // Sign extremes, loaded through a reload from RUN
      for (int i = 0; i < DEPTH; i++) begin m_tap[0][i] = 32767; m_tap[1][i] = -32768; end
      m_bias[0] = -32768; m_bias[1] = 32767;
      load_taps(1'b0);
      for (int e = 0; e < DEPTH; e++) feed(-32768, e == 0);
      chk("exp_extreme_l0", exp_out[0], -64'sd4294868992);
      drain(0);

      // Reload collides with valid data at index 0
      for (int i = 0; i < DEPTH; i++) begin m_tap[0][i] = 2; m_tap[1][i] = (i == 0) ? 3 : 0; end
      m_bias[0] = 0; m_bias[1] = 1;
      bif.tap_in = 16'd2; bif.tap_in_vld = 1'b1; bif.tap_in_fst = 1'b1;
      bif.stage_data = 16'd7; bif.stage_data_vld = 1'b1; bif.stage_data_fst = 1'b1;
      #1;
      chk("reload_tap_rdy", bif.tap_in_rdy, 1);
      chk("reload_data_rdy", bif.stage_data_rdy, 0);
      @(posedge clk);
      @(negedge clk);
      bif.tap_in_vld = 1'b0; bif.tap_in_fst = 1'b0;
      bif.stage_data_vld = 1'b0; bif.stage_data_fst = 1'b0;
      load_taps(1'b1);
      feed_ones();
      chk("exp_reload_l0", exp_out[0], 8);
      drain(0);

      // Randomized coefficients and vectors, with discarded prefixes and random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < DEPTH; i++) m_tap[l][i] = rnd16();
            m_bias[l] = rnd16();
         end
         load_taps(1'b0);
         for (int v = 0; v < 3; v++) begin
            int pre;
            pre = $urandom_range(0, DEPTH - 1);
            for (int e = 0; e < pre; e++)
               feed(rnd16(), (e == 0) ? ($urandom_range(0, 1) == 1) : 1'b0);
            for (int e = 0; e < DEPTH; e++) feed(rnd16(), e == 0);
            drain(2);
         end
      end

      // Reset while lane 0 is pending
      set_basic_taps();
      load_taps(1'b0);
      bif.stage_data_out_rdy = 1'b0;
      feed_ones();
      chk("pend_vld", bif.stage_data_out_vld, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_vld", bif.stage_data_out_vld, 0);
      chk("mid_rst_out", out_val(), 0);
      chk("mid_rst_tap_rdy", bif.tap_in_rdy, 0);
      chk("mid_rst_data_rdy", bif.stage_data_rdy, 0);
      reset = 1'b0;
      bif.stage_data_out_rdy = 1'b1;
      #1;
      chk("post_mid_rst_tap_rdy", bif.tap_in_rdy, 1);
      bif.stage_data = 16'd1; bif.stage_data_vld = 1'b1; bif.stage_data_fst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("unloaded_data_rdy", bif.stage_data_rdy, 0);
         chk("unloaded_out_vld", bif.stage_data_out_vld, 0);
      end
      bif.stage_data_vld = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
